// File: rtl/calc_pkg.sv
// Shared encodings and constants for the calculator operand-entry path.
// Field/state codes double as the display mux select.
package calc_pkg;

  localparam int OPW         = 12;
  localparam int DEB_DEFAULT = 4;

  typedef enum logic [1:0] {
    S_R0   = 2'd0,
    S_R1   = 2'd1,
    S_RS   = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/operand_entry_if.sv
// Switch/button inputs and operand outputs of the entry block.
// master drives the buttons; slave is the entry block itself.
interface operand_entry_if;
  import calc_pkg::*;

  logic [3:0]     sw;
  logic           btn_load;
  logic           btn_next;
  logic           btn_clr;
  logic [OPW-1:0] r0;
  logic [OPW-1:0] r1;
  logic [3:0]     rs;
  logic [1:0]     field;
  logic           valid;

  modport master (
    output sw, btn_load, btn_next, btn_clr,
    input  r0, r1, rs, field, valid
  );

  modport slave (
    input  sw, btn_load, btn_next, btn_clr,
    output r0, r1, rs, field, valid
  );

endinterface

// File: rtl/btn_debounce.sv
// Raw push button -> 2-flop sync -> stable-count debounce -> press pulse.
// The pulse fires once per debounced 0->1 edge, so a held button never repeats.
module btn_debounce #(
  parameter int DEB_CYCLES = calc_pkg::DEB_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DEB_CYCLES) + 1;

  logic          s1;
  logic          s2;
  logic          deb;
  logic          deb_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      deb   <= 1'b0;
      deb_q <= 1'b0;
      cnt   <= '0;
    end else begin
      s1    <= btn;
      s2    <= s1;
      deb_q <= deb;
      if (s2 == deb) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        deb <= ~deb;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press = deb & ~deb_q;

endmodule

// File: rtl/operand_entry.sv
// Nibble-wise entry of operands A, B and the ALU op from switches.
// Buttons: load shifts sw in, next steps field, clr wipes (clr > load > next).
module operand_entry
  import calc_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     sw,
  input  logic           btn_load,
  input  logic           btn_next,
  input  logic           btn_clr,
  output logic [OPW-1:0] r0,
  output logic [OPW-1:0] r1,
  output logic [3:0]     rs,
  output logic [1:0]     field,
  output logic           valid
);

  logic   load_p;
  logic   next_p;
  logic   clr_p;
  state_t state;
  state_t state_nx;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_load (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_load),
    .press (load_p)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_next (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_next),
    .press (next_p)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_clr (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_clr),
    .press (clr_p)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_R0;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (clr_p) begin
      if (state == S_DONE) state_nx = S_R0;
    end else if (!load_p && next_p) begin
      unique case (state)
        S_R0:   state_nx = S_R1;
        S_R1:   state_nx = S_RS;
        S_RS:   state_nx = S_DONE;
        S_DONE: state_nx = S_R0;
      endcase
    end
  end

  always_comb begin
    field = state;
    valid = (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r0 <= '0;
      r1 <= '0;
      rs <= '0;
    end else if (clr_p) begin
      unique case (state)
        S_R0: r0 <= '0;
        S_R1: r1 <= '0;
        S_RS: rs <= '0;
        S_DONE: begin
          r0 <= '0;
          r1 <= '0;
          rs <= '0;
        end
      endcase
    end else if (load_p) begin
      unique case (state)
        S_R0:   r0 <= {r0[OPW-5:0], sw};
        S_R1:   r1 <= {r1[OPW-5:0], sw};
        S_RS:   rs <= sw;
        S_DONE: ;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_entry.sv
// Directed bench for operand_entry with DEB_CYCLES=4.
// Each scenario task checks its own expected values.
module tb_operand_entry;
  import calc_pkg::*;

  localparam int DEB = 4;
  localparam int LAT = DEB + 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  operand_entry_if bus ();

  operand_entry #(.DEB_CYCLES(DEB)) dut (
    .clk      (clk),
    .rst      (rst),
    .sw       (bus.sw),
    .btn_load (bus.btn_load),
    .btn_next (bus.btn_next),
    .btn_clr  (bus.btn_clr),
    .r0       (bus.r0),
    .r1       (bus.r1),
    .rs       (bus.rs),
    .field    (bus.field),
    .valid    (bus.valid)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    bus.btn_load = 1'b0;
    bus.btn_next = 1'b0;
    bus.btn_clr  = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // b = {clr, load, next}; held for the full latency, then released and settled
  task automatic press(input logic [2:0] b, input logic [3:0] v);
    @(negedge clk);
    bus.sw = v;
    {bus.btn_clr, bus.btn_load, bus.btn_next} = b;
    repeat (LAT) @(posedge clk);
    @(negedge clk);
    {bus.btn_clr, bus.btn_load, bus.btn_next} = 3'b000;
    repeat (LAT + 1) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.r0 !== 12'h000) begin
      errors++;
      $display("FAIL reset_r0 got %h want 000", bus.r0);
    end
    checks++;
    if (bus.r1 !== 12'h000) begin
      errors++;
      $display("FAIL reset_r1 got %h want 000", bus.r1);
    end
    checks++;
    if (bus.rs !== 4'h0) begin
      errors++;
      $display("FAIL reset_rs got %h want 0", bus.rs);
    end
    checks++;
    if (bus.field !== 2'd0) begin
      errors++;
      $display("FAIL reset_field got %0d want 0", bus.field);
    end
    checks++;
    if (bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got %b want 0", bus.valid);
    end
  endtask

  task automatic test_entry();
    do_reset();
    press(3'b010, 4'h1);
    press(3'b010, 4'h2);
    press(3'b010, 4'h3);
    checks++;
    if (bus.r0 !== 12'h123) begin
      errors++;
      $display("FAIL entry_r0 got %h want 123", bus.r0);
    end
    press(3'b001, 4'h0);
    checks++;
    if (bus.field !== 2'd1) begin
      errors++;
      $display("FAIL entry_field1 got %0d want 1", bus.field);
    end
    press(3'b010, 4'hA);
    press(3'b010, 4'hB);
    checks++;
    if (bus.r1 !== 12'h0AB) begin
      errors++;
      $display("FAIL entry_r1 got %h want 0ab", bus.r1);
    end
    press(3'b001, 4'h0);
    checks++;
    if (bus.field !== 2'd2) begin
      errors++;
      $display("FAIL entry_field2 got %0d want 2", bus.field);
    end
    press(3'b010, 4'h5);
    checks++;
    if (bus.rs !== 4'h5) begin
      errors++;
      $display("FAIL entry_rs got %h want 5", bus.rs);
    end
    checks++;
    if (bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL entry_valid_early got %b want 0", bus.valid);
    end
    press(3'b001, 4'h0);
    checks++;
    if (bus.field !== 2'd3 || bus.valid !== 1'b1) begin
      errors++;
      $display("FAIL entry_done got field=%0d valid=%b want 3/1",
               bus.field, bus.valid);
    end
  endtask

  // runs right after test_entry, so the block sits in DONE
  task automatic test_wrap();
    press(3'b010, 4'h7);
    checks++;
    if (bus.r0 !== 12'h123 || bus.r1 !== 12'h0AB || bus.rs !== 4'h5) begin
      errors++;
      $display("FAIL wrap_load_done got %h/%h/%h want 123/0ab/5",
               bus.r0, bus.r1, bus.rs);
    end
    checks++;
    if (bus.field !== 2'd3) begin
      errors++;
      $display("FAIL wrap_load_state got %0d want 3", bus.field);
    end
    press(3'b001, 4'h0);
    checks++;
    if (bus.field !== 2'd0 || bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_field got field=%0d valid=%b want 0/0",
               bus.field, bus.valid);
    end
    checks++;
    if (bus.r0 !== 12'h123 || bus.r1 !== 12'h0AB || bus.rs !== 4'h5) begin
      errors++;
      $display("FAIL wrap_keep got %h/%h/%h want 123/0ab/5",
               bus.r0, bus.r1, bus.rs);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    press(3'b010, 4'hF);
    press(3'b010, 4'h1);
    press(3'b010, 4'h2);
    press(3'b010, 4'h3);
    checks++;
    if (bus.r0 !== 12'h123) begin
      errors++;
      $display("FAIL overflow_r0 got %h want 123", bus.r0);
    end
  endtask

  task automatic test_bounce();
    logic [9:0] pat;
    pat = 10'b0100101101;
    do_reset();
    bus.sw = 4'h4;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.btn_load = pat[i];
    end
    @(negedge clk);
    bus.btn_load = 1'b1;
    repeat (LAT - 1) @(posedge clk);
    #1;
    checks++;
    if (bus.r0 !== 12'h000) begin
      errors++;
      $display("FAIL bounce_early got %h want 000", bus.r0);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.r0 !== 12'h004) begin
      errors++;
      $display("FAIL bounce_latency got %h want 004", bus.r0);
    end
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if (bus.r0 !== 12'h004) begin
      errors++;
      $display("FAIL bounce_hold got %h want 004", bus.r0);
    end
    @(negedge clk);
    bus.btn_load = 1'b0;
    repeat (LAT + 1) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.r0 !== 12'h004) begin
      errors++;
      $display("FAIL bounce_release got %h want 004", bus.r0);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    press(3'b010, 4'h9);
    press(3'b001, 4'h0);
    press(3'b010, 4'h4);
    press(3'b010, 4'h5);
    checks++;
    if (bus.r1 !== 12'h045) begin
      errors++;
      $display("FAIL simul_setup got %h want 045", bus.r1);
    end
    press(3'b110, 4'h8);
    checks++;
    if (bus.r1 !== 12'h000 || bus.field !== 2'd1) begin
      errors++;
      $display("FAIL simul_clr_load got r1=%h field=%0d want 000/1",
               bus.r1, bus.field);
    end
    checks++;
    if (bus.r0 !== 12'h009) begin
      errors++;
      $display("FAIL simul_r0_kept got %h want 009", bus.r0);
    end
    press(3'b001, 4'h0);
    press(3'b010, 4'h6);
    press(3'b011, 4'h3);
    checks++;
    if (bus.rs !== 4'h3 || bus.field !== 2'd2) begin
      errors++;
      $display("FAIL simul_load_next got rs=%h field=%0d want 3/2",
               bus.rs, bus.field);
    end
    press(3'b001, 4'h0);
    checks++;
    if (bus.valid !== 1'b1) begin
      errors++;
      $display("FAIL simul_done got %b want 1", bus.valid);
    end
    press(3'b100, 4'h0);
    checks++;
    if (bus.r0 !== 12'h000 || bus.r1 !== 12'h000 || bus.rs !== 4'h0) begin
      errors++;
      $display("FAIL simul_clr_done got %h/%h/%h want 000/000/0",
               bus.r0, bus.r1, bus.rs);
    end
    checks++;
    if (bus.field !== 2'd0 || bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL simul_clr_state got field=%0d valid=%b want 0/0",
               bus.field, bus.valid);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    press(3'b010, 4'h1);
    press(3'b010, 4'h2);
    press(3'b001, 4'h0);
    checks++;
    if (bus.r0 !== 12'h012 || bus.field !== 2'd1) begin
      errors++;
      $display("FAIL rstmid_setup got r0=%h field=%0d want 012/1",
               bus.r0, bus.field);
    end
    @(negedge clk);
    bus.sw = 4'h7;
    bus.btn_load = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.r0 !== 12'h000 || bus.field !== 2'd0) begin
      errors++;
      $display("FAIL rstmid_clear got r0=%h field=%0d want 000/0",
               bus.r0, bus.field);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (LAT - 1) @(posedge clk);
    #1;
    checks++;
    if (bus.r0 !== 12'h000) begin
      errors++;
      $display("FAIL rstmid_early got %h want 000", bus.r0);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.r0 !== 12'h007) begin
      errors++;
      $display("FAIL rstmid_held_pulse got %h want 007", bus.r0);
    end
    repeat (20) @(posedge clk);
    @(negedge clk);
    bus.btn_load = 1'b0;
    checks++;
    if (bus.r0 !== 12'h007) begin
      errors++;
      $display("FAIL rstmid_single got %h want 007", bus.r0);
    end
  endtask

  initial begin
    bus.sw       = 4'h0;
    bus.btn_load = 1'b0;
    bus.btn_next = 1'b0;
    bus.btn_clr  = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    test_reset();
    test_entry();
    test_wrap();
    test_overflow();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_entry.md
OPERAND_ENTRY -- requirements
Module: operand_entry

Interface
REQ-001 The block SHALL have parameter DEB_CYCLES, default 4, giving the consecutive stable cycles needed to accept a button change (board build uses 250000).
REQ-002 The block SHALL have one clock and one reset; the reset SHALL be synchronous and active-high.
REQ-003 Port clk, input, 1 bit: system clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: synchronous active-high reset.
REQ-005 Port sw, input, 4 bits: nibble value from the slide switches, sampled at load.
REQ-006 Port btn_load, input, 1 bit: raw asynchronous push button that shifts sw into the current field.
REQ-007 Port btn_next, input, 1 bit: raw asynchronous push button that advances to the next field.
REQ-008 Port btn_clr, input, 1 bit: raw asynchronous push button that clears the current field.
REQ-009 Port r0, output, 12 bits: operand A, feeding the ALU a input.
REQ-010 Port r1, output, 12 bits: operand B, feeding the ALU b input.
REQ-011 Port rs, output, 4 bits: ALU operation select.
REQ-012 Port field, output, 2 bits: current field (0=R0, 1=R1, 2=RS, 3=DONE), feeding the display mux select.
REQ-013 Port valid, output, 1 bit: high only in DONE, meaning r0, r1 and rs are complete.

Function
REQ-014 Each button SHALL pass through a 2-flop synchronizer, then a debouncer that holds a debounced level deb.
REQ-015 The debounce counter SHALL increment each cycle the synchronized level differs from deb, and SHALL clear whenever they are equal.
REQ-016 When the debounce counter equals DEB_CYCLES-1 while the levels still differ, deb SHALL toggle on the next edge and the counter SHALL clear.
REQ-017 Each debouncer SHALL emit a press pulse, high for exactly one cycle, on each 0->1 transition of deb; releases and glitches shorter than DEB_CYCLES SHALL produce no pulse.
REQ-018 The FSM SHALL have states S_R0, S_R1, S_RS and S_DONE, and field SHALL equal the state encoding 0..3.
REQ-019 A load pulse in S_R0 SHALL set r0 <= {r0[7:0], sw} at the same edge; bits shifted out of the top are discarded, with no overflow flag.
REQ-020 A load pulse in S_R1 SHALL set r1 <= {r1[7:0], sw}.
REQ-021 A load pulse in S_RS SHALL set rs <= sw.
REQ-022 A load pulse in S_DONE SHALL be ignored.
REQ-023 A next pulse SHALL step the state S_R0->S_R1->S_RS->S_DONE->S_R0, with wrap-around; the S_DONE->S_R0 step SHALL keep all register values.
REQ-024 A clr pulse SHALL zero only the current field's register and SHALL not change the state.
REQ-025 A clr pulse in S_DONE SHALL zero r0, r1 and rs and SHALL move the state to S_R0.
REQ-026 When pulses coincide in one cycle, the priority SHALL be clr > load > next; the lower-priority pulses are dropped, not queued.
REQ-027 valid SHALL equal (state == S_DONE), decoded from the registered state with no extra delay.
REQ-028 Latency from the first rising edge at which a raw button is sampled high, then held, to the register or state update SHALL be DEB_CYCLES+3 edges (2 synchronizer + DEB_CYCLES + 1 update).
REQ-029 A button held high indefinitely SHALL produce exactly one pulse; there SHALL be no auto-repeat.

Reset
REQ-030 On rst high at a clock edge, r0, r1 and rs SHALL be 0, the state SHALL be S_R0 (field=0, valid=0), synchronizers, deb and counters SHALL be 0, and no pulse SHALL be pending.
REQ-031 Reset asserted mid-debounce or mid-entry SHALL discard the partial count and the entry.
REQ-032 A button still held when rst falls SHALL produce one pulse after the full debounce latency, counted from the first post-reset edge.

Structure
REQ-033 The shared package calc_pkg SHALL hold the state/field encodings (S_R0..S_DONE), the operand width constant (12) and the DEB_CYCLES default.
REQ-034 The block SHALL use one sub-module, btn_debounce (synchronizer, counter, deb, press pulse), instantiated three times.
REQ-035 The counter width SHALL be clog2(DEB_CYCLES)+1.

Verification
REQ-036 Bench scenario, entry: reset, then load sw=1,2,3 in S_R0 -> r0=0x123; next -> field=1; load 0xA,0xB -> r1=0x0AB; next -> field=2; load 5 -> rs=5; next -> field=3, valid=1.
REQ-037 Bench scenario, overflow: four loads of 0xF,0x1,0x2,0x3 in S_R0 -> r0=0x123, top nibble dropped.
REQ-038 Bench scenario, bounce: btn_load toggling every 1-2 cycles for 10 cycles, then held high -> exactly one load, DEB_CYCLES+3 edges after the stable high; a held button gives no further loads.
REQ-039 Bench scenario, simultaneous press: clr and load presented together in S_R1 with r1=0x045 -> r1=0, state unchanged; clr in S_DONE -> all registers 0, field=0, valid=0.
REQ-040 Bench scenario, reset: rst asserted mid-entry with r0=0x012 -> next edge r0=0, field=0; a button held through reset -> one pulse after DEB_CYCLES+3 edges.
REQ-041 Bench scenario, wrap-around: next in S_DONE -> field=0 with r0, r1 and rs preserved; a load in S_DONE leaves all registers unchanged.
